// File: rtl/hack_word_serializer.sv
// Parallel-in, serial-out word transmitter for the 16-bit serial-in shift
// register load path. A word accepted over valid/ready is shifted out MSB
// first on sdo_o, with one sen_o strobe per bit. Each bit lasts CLK_DIV cycles.
//
// Optional build macro: HACK_SERIALIZER_SKID_EN
//   undefined (default): no buffering. ready_o is high only in IDLE.
//   defined            : a one-entry holding buffer allows back-to-back words
//                        with no gap between them (word period WIDTH*CLK_DIV).
module hack_word_serializer #(
    parameter int WIDTH   = 16,   // 2..32
    parameter int CLK_DIV = 1     // 1..256
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             sdo_o,
    output logic             sen_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [BCW-1:0]   bit_cnt;
    logic [DCW-1:0]   div_cnt;
    logic             done_q;
    logic             accept;
    logic             last_bit;
    logic             reload;        // start another word right at the last-bit edge
    logic [WIDTH-1:0] reload_word;

    assign busy_o   = (state == SHIFT);
    assign sen_o    = busy_o && (div_cnt == DIV_LAST);
    assign sdo_o    = busy_o && shift_reg[WIDTH-1];
    assign done_o   = done_q;
    assign last_bit = sen_o && (bit_cnt == BIT_LAST);
    assign accept   = valid_i && ready_o;

`ifdef HACK_SERIALIZER_SKID_EN
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;

    // The producer is stalled only while a word already waits in the buffer
    assign ready_o     = !hold_full;
    assign reload      = hold_full || accept;
    assign reload_word = hold_full ? hold_data : data_i;

    // Holding buffer: capture a word accepted mid-shift, drain it at the last-bit edge
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (busy_o && last_bit) begin
            hold_full <= 1'b0;
        end else if (busy_o && accept) begin
            hold_data <= data_i;
            hold_full <= 1'b1;
        end
    end
`else
    assign ready_o     = (state == IDLE);
    assign reload      = 1'b0;
    assign reload_word = data_i;
`endif

    // FSM, shift register, bit and divider counters, and the done pulse
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    shift_reg <= data_i;
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                    state     <= SHIFT;
                end
            end else begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                if (sen_o) begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                if (last_bit) begin
                    done_q  <= 1'b1;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    if (reload)
                        shift_reg <= reload_word;
                    else
                        state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_word_serializer.sv
// Scoreboard bench for hack_word_serializer. Two instances are used, one with
// CLK_DIV=1 and one with CLK_DIV=4. Each instance drives its own receiver
// shift register. The stimulus pushes the expected word and the expected
// done_o cycle. A negedge monitor checks each done_o pulse against the queue.
module tb_hack_word_serializer;

    localparam int W = 16;
`ifdef HACK_SERIALIZER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        int         inst;
        logic [W-1:0] word;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetb = 1'b0;
    logic [W-1:0] data [2];
    logic [1:0]   valid;
    logic [1:0]   ready, sdo, sen, busy, done;
    logic [W-1:0] rx [2];
    int           cyc = 0;

    exp_t sb[$];
    int   last_exp [2] = '{0, 0};
    int   nstb [2] = '{0, 0};
    int   nhi  [2] = '{0, 0};
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hack_word_serializer #(.WIDTH(W), .CLK_DIV(g == 0 ? 1 : 4)) u_dut (
            .clk     (clk),
            .resetb  (resetb),
            .data_i  (data[g]),
            .valid_i (valid[g]),
            .ready_o (ready[g]),
            .sdo_o   (sdo[g]),
            .sen_o   (sen[g]),
            .busy_o  (busy[g]),
            .done_o  (done[g])
        );

        // Downstream serial-in shift register sharing resetb
        always @(posedge clk or negedge resetb) begin
            if (!resetb)     rx[g] <= '0;
            else if (sen[g]) rx[g] <= {rx[g][W-2:0], sdo[g]};
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pop the oldest expectation for an instance on each done_o pulse
    always @(negedge clk) begin
        int idx;
        if (!resetb) begin
            sb.delete();
            nstb = '{0, 0};
            nhi  = '{0, 0};
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (done[g]) begin
                    idx = -1;
                    foreach (sb[i]) if (idx < 0 && sb[i].inst == g) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_done%0d", g), 1, 0);
                    end else begin
                        chk($sformatf("rx_word%0d", g), rx[g], sb[idx].word);
                        chk($sformatf("done_cycle%0d", g), cyc, sb[idx].cyc);
                        chk($sformatf("strobes%0d", g), nstb[g], W);
                        chk($sformatf("sdo_hi_cycles%0d", g), nhi[g],
                            $countones(sb[idx].word) * (g == 0 ? 1 : 4));
                        sb.delete(idx);
                    end
                    nstb[g] = int'(sen[g]);
                    nhi[g]  = int'(sdo[g]);
                end else begin
                    nstb[g] += int'(sen[g]);
                    nhi[g]  += int'(sdo[g]);
                end
            end
        end
    end

    // Present a word at a negedge and wait until it is accepted. c is the cycle
    // index just before the accepting edge. The word cannot finish before its own
    // serialization completes, or before one word period after the previous word.
    task automatic send(input int g, input logic [W-1:0] w, output int c);
        int wd;
        exp_t e;
        wd = W * (g == 0 ? 1 : 4);
        c = -1;
        data[g]  = w;
        valid[g] = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            if (ready[g]) begin
                c = cyc;
                e.inst = g;
                e.word = w;
                e.cyc  = (c + wd + 1 > last_exp[g] + wd) ? c + wd + 1 : last_exp[g] + wd;
                last_exp[g] = e.cyc;
                sb.push_back(e);
                @(posedge clk);
                @(negedge clk);
                valid[g] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        valid[g] = 1'b0;
        chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            if (sb.size() == 0 && busy == 2'b00) return;
            @(negedge clk);
        end
        chk("idle_timeout", sb.size(), 0);
    endtask

    initial begin
        int c, c1, c2, n;
        valid   = 2'b00;
        data[0] = '0;
        data[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 2'b00);
        chk("rst_sen",  sen,  2'b00);
        chk("rst_sdo",  sdo,  2'b00);
        chk("rst_done", done, 2'b00);
        resetb = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 2'b11);

        // 1: A5C3 at CLK_DIV=1. ready_o is low for the whole word unless buffered.
        send(0, 16'hA5C3, c);
        n = 0;
        for (int t = 0; t < 40 && !ready[0]; t++) begin
            n++;
            @(negedge clk);
        end
        chk("t1_ready_low", n, SKID ? 0 : 16);
        wait_idle();

        // 2: 8001 at CLK_DIV=4. The strobe and sdo-high counts are checked by the monitor.
        send(1, 16'h8001, c);
        wait_idle();

        // 3: valid held across two words
        send(0, 16'h1234, c1);
        send(0, 16'hFFFF, c2);
        chk("t3_accept_gap", c2 - c1, SKID ? 1 : 17);
        wait_idle();

        // 4: three-word stream, and a two-word stream at CLK_DIV=4
        send(0, 16'h0001, c1);
        send(0, 16'h8000, c2);
        chk("t4_ready_low", ready[0], 1'b0);
        send(0, 16'hFFFF, c);
        send(1, 16'h5A5A, c1);
        send(1, 16'h0F0F, c2);
        wait_idle();

        // 5: reset after the 7th strobe of FFFF drops the word with no done_o
        send(0, 16'hFFFF, c);
        n = 0;
        for (int t = 0; t < 100 && n < 7; t++) begin
            if (sen[0]) n++;
            if (n < 7) @(negedge clk);
        end
        chk("t5_seven_strobes", n, 7);
        @(posedge clk);
        #2 resetb = 1'b0;
        #1;
        chk("t5_rst_outs", {sdo[0], sen[0], busy[0], done[0]}, 4'b0000);
        last_exp = '{0, 0};
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", ready[0], 1'b1);
        send(0, 16'h00FF, c);
        wait_idle();

        // 6: offer the next word during the last strobe cycle
        send(0, 16'hC001, c1);
        repeat (15) @(negedge clk);
        send(0, 16'h3FFE, c2);
        chk("t6_accept_at", c2 - c1, SKID ? 16 : 17);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

endmodule
